// File: rtl/input_conditioner.sv
// input_conditioner: two-flop sync, per-bit debounce, press/release/change pulses.
// Define INPUT_CONDITIONER_AUTOREPEAT_EN to add per-button auto-repeat on btn_press.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BTN_WIDTH       = 3,
   parameter int SW_WIDTH        = 10,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BTN_WIDTH-1:0] btn,
   input  logic [SW_WIDTH-1:0]  sw,
   output logic [BTN_WIDTH-1:0] btn_level,
   output logic [BTN_WIDTH-1:0] btn_press,
   output logic [BTN_WIDTH-1:0] btn_release,
   output logic [SW_WIDTH-1:0]  sw_level,
   output logic                 sw_changed
);
   localparam int N  = BTN_WIDTH + SW_WIDTH;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [BTN_WIDTH-1:0] r_btn_s1, r_btn_s2, r_btn_press, r_btn_release;
   logic [SW_WIDTH-1:0]  r_sw_s1, r_sw_s2;
   logic                 r_sw_changed;
   logic [N-1:0]         w_sample, w_diff, w_flip, w_level_nxt, r_level;
   logic [CW-1:0]        r_cnt [N];
   logic [CW-1:0]        w_cnt_nxt [N];
   logic [BTN_WIDTH-1:0] w_btn_hold, w_rep_fire;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_s1 <= '1;
         r_btn_s2 <= '1;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_btn_s1 <= btn;
         r_btn_s2 <= r_btn_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end
   // Buttons are active-low on the board; everything past the sync is active-high.
   assign w_sample    = {r_sw_s2, ~r_btn_s2};
   assign w_diff      = w_sample ^ r_level;
   assign w_level_nxt = r_level ^ w_flip;
   assign w_btn_hold  = r_level[BTN_WIDTH-1:0] & w_level_nxt[BTN_WIDTH-1:0];
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_flip[i]    = w_diff[i] && (r_cnt[i] == CNT_LAST);
         w_cnt_nxt[i] = (!w_diff[i] || w_flip[i]) ? '0 : r_cnt[i] + CW'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level       <= '0;
         r_btn_press   <= '0;
         r_btn_release <= '0;
         r_sw_changed  <= 1'b0;
         for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      end else begin
         r_level       <= w_level_nxt;
         r_btn_press   <= (w_flip[BTN_WIDTH-1:0] & w_level_nxt[BTN_WIDTH-1:0]) | w_rep_fire;
         r_btn_release <= w_flip[BTN_WIDTH-1:0] & ~w_level_nxt[BTN_WIDTH-1:0];
         r_sw_changed  <= |w_flip[N-1:BTN_WIDTH];
         for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
   logic [RW-1:0]        r_rep_cnt [BTN_WIDTH];
   logic [BTN_WIDTH-1:0] r_rep_periodic, w_rep_hit;
   always_comb begin
      for (int i = 0; i < BTN_WIDTH; i++)
         w_rep_hit[i] = r_rep_cnt[i] == (r_rep_periodic[i] ? PERIOD_LAST : DELAY_LAST);
   end
   // Only a level that is 1 before and after the edge may repeat, so the release edge never fires.
   assign w_rep_fire = w_btn_hold & w_rep_hit;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep_periodic <= '0;
         for (int i = 0; i < BTN_WIDTH; i++) r_rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < BTN_WIDTH; i++) begin
            if (!w_btn_hold[i]) begin
               r_rep_cnt[i]      <= '0;
               r_rep_periodic[i] <= 1'b0;
            end else if (w_rep_hit[i]) begin
               r_rep_cnt[i]      <= '0;
               r_rep_periodic[i] <= 1'b1;
            end else begin
               r_rep_cnt[i]      <= r_rep_cnt[i] + RW'(1);
            end
         end
      end
   end
`else
   logic w_unused_rep;
   assign w_rep_fire   = '0;
   assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD, w_btn_hold};
`endif
   assign btn_level   = r_level[BTN_WIDTH-1:0];
   assign sw_level    = r_level[N-1:BTN_WIDTH];
   assign btn_press   = r_btn_press;
   assign btn_release = r_btn_release;
   assign sw_changed  = r_sw_changed;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed + random stimulus against a sliding-window debounce model.
module tb_input_conditioner;
   localparam int D  = 4;
   localparam int B  = 3;
   localparam int S  = 10;
   localparam int RD = 8;
   localparam int RP = 3;
   localparam int N  = B + S;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [B-1:0] btn = '1;
   logic [S-1:0] sw = '0;
   logic [B-1:0] btn_level, btn_press, btn_release;
   logic [S-1:0] sw_level;
   logic         sw_changed;
   int           n_checks = 0;
   int           n_fail = 0;
   int           edge_no = 0;
   logic [N-1:0] raw_q[$];
   logic [N-1:0] samp_q[$];
   logic [N-1:0] m_level;
   logic [B-1:0] m_press, m_release;
   logic         m_changed;
   int           press_edge [B];

   always #5 clk = ~clk;

   input_conditioner #(
      .DEBOUNCE_CYCLES(D), .BTN_WIDTH(B), .SW_WIDTH(S),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .sw_level(sw_level), .sw_changed(sw_changed)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      samp_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_changed = 1'b0;
      for (int i = 0; i < B; i++) press_edge[i] = 0;
   endtask

   task automatic check_all(input string ph);
      chk({ph, "btn_level"},   32'(btn_level),   32'(m_level[B-1:0]));
      chk({ph, "btn_press"},   32'(btn_press),   32'(m_press));
      chk({ph, "btn_release"}, 32'(btn_release), 32'(m_release));
      chk({ph, "sw_level"},    32'(sw_level),    32'(m_level[N-1:B]));
      chk({ph, "sw_changed"},  32'(sw_changed),  32'(m_changed));
   endtask

   // A bit flips once the last D synchronized samples all disagree with its accepted level;
   // the sample seen at an edge is the raw value captured two edges earlier.
   task automatic step(input logic [B-1:0] b, input logic [S-1:0] s);
      logic [N-1:0] all_diff, nl;
      int t;
      btn = b;
      sw  = s;
      @(posedge clk);
      edge_no++;
      raw_q.push_back({s, ~b});
      samp_q.push_back(raw_q[0]);
      void'(raw_q.pop_front());
      if (samp_q.size() > D) void'(samp_q.pop_front());
      all_diff = (samp_q.size() == D) ? '1 : '0;
      foreach (samp_q[j]) all_diff &= samp_q[j] ^ m_level;
      nl        = m_level ^ all_diff;
      m_press   = all_diff[B-1:0] & nl[B-1:0];
      m_release = all_diff[B-1:0] & ~nl[B-1:0];
      m_changed = |all_diff[N-1:B];
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      for (int i = 0; i < B; i++) begin
         if (m_press[i]) press_edge[i] = edge_no;
         else if (m_level[i] && nl[i]) begin
            t = edge_no - press_edge[i];
            if (t == RD || (t > RD && (t - RD) % RP == 0)) m_press[i] = 1'b1;
         end
      end
`else
      t = 0;
`endif
      m_level = nl;
      #1;
      check_all("");
   endtask

   task automatic reset_for(input int cycles);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("rst_");
      repeat (cycles) @(posedge clk);
      #2 check_all("rst_");
      rst_n = 1'b1;
   endtask

   task automatic hold(input int n, input logic [B-1:0] b, input logic [S-1:0] s);
      repeat (n) step(b, s);
   endtask

   initial begin
      logic [B-1:0] rb;
      logic [S-1:0] rs;
      int k;
      model_reset();
      reset_for(3);
      hold(5, 3'b111, '0);
      hold(12, 3'b110, '0);
      hold(10, 3'b111, '0);
      for (int i = 0; i < 6; i++) begin
         hold(2, 3'b101, '0);
         hold(2, 3'b111, '0);
      end
      hold(10, 3'b101, '0);
      hold(10, 3'b111, '0);
      hold(3, 3'b011, '0);
      hold(10, 3'b111, '0);
      hold(10, 3'b111, 10'h201);
      hold(10, 3'b111, '0);
      hold(2, 3'b111, 10'h008);
      reset_for(2);
      hold(10, 3'b111, 10'h008);
      hold(25, 3'b110, 10'h008);
      hold(10, 3'b111, 10'h008);
      hold(6, 3'b000, 10'h3ff);
      hold(8, 3'b111, '0);
      rb = '1;
      rs = '0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            k = $urandom_range(N - 1, 0);
            if (k < B) rb[k] = ~rb[k];
            else rs[k-B] = ~rs[k-B];
         end
         if ($urandom_range(400, 0) == 0) reset_for($urandom_range(3, 1));
         step(rb, rs);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
